nsdp_error_arbiter: RTL
=======================

Name: nsdp_error_arbiter

Overview:
- Sits between the two per-channel NSDP packet checkers and the AXI register block.
- Each checker presents an error record on a valid/ready handshake.
- This block arbitrates both channels into one shared snapshot buffer (code + 512-bit data + channel ID), so the register block needs only one error-data window.
- Sequences capture via an arm/hold state machine driven by software pulses, and keeps per-channel error counts.

Parameters:
DATA_W, 512, width of error-data snapshot
CODE_W, 15, width of error code
CNT_W, 32, width of per-channel error counters

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
ch0_err_valid  in  1  ch0 checker has an error record
ch0_err_ready  out  1  ch0 record accepted this cycle
ch0_err_code  in  CODE_W  ch0 error code (nonzero when valid)
ch0_err_data  in  DATA_W  ch0 offending data beat
ch1_err_valid  in  1  ch1 checker has an error record
ch1_err_ready  out  1  ch1 record accepted this cycle
ch1_err_code  in  CODE_W  ch1 error code
ch1_err_data  in  DATA_W  ch1 offending data beat
arm  in  1  one-cycle pulse: enable capture of next error
clear  in  1  one-cycle pulse: zero counters, drop snapshot, disarm
state  out  2  0=IDLE, 1=ARMED, 2=HELD
cap_valid  out  1  snapshot holds a captured record
cap_channel  out  1  channel of captured record
cap_code  out  CODE_W  captured error code
cap_data  out  DATA_W  captured error data
cap_time  out  32  capture timestamp (see Optional Feature)
ch0_err_count  out  CNT_W  ch0 errors accepted since clear
ch1_err_count  out  CNT_W  ch1 errors accepted since clear
irq  out  1  one-cycle pulse on capture

Behaviour:
- Reset, while resetn=0 at a clk edge:
  - state=IDLE, cap_valid=0, cap_channel=0, cap_code=0, cap_data=0, cap_time=0, counts=0, irq=0.
  - last_grant=1, so ch0 wins the first tie.
- Reset mid-handshake: the record is not accepted; ready outputs are 0 while resetn=0.
- Grant (combinational, at most one per cycle, never blocks):
  - Only one valid: grant that channel.
  - Both valid: grant the channel != last_grant.
  - last_grant updates on every accepted transfer.
  - chN_err_ready = grant_N. Transfer = valid && ready, taken on the same edge. Zero-latency acceptance.
- Counting:
  - Each transfer increments that channel's counter by 1.
  - Counters saturate at 2^CNT_W-1; no wrap.
- State machine:
  - IDLE: transfers counted, not captured. arm -> ARMED next cycle. A transfer in the same cycle as arm is not captured.
  - ARMED: the first transfer loads cap_channel/cap_code/cap_data/cap_time and sets cap_valid=1 on the same edge. Then irq=1 for one cycle, next state HELD. arm while ARMED is a no-op.
  - HELD: snapshot frozen; further transfers counted only.
    - arm -> cap_valid=0, ARMED next cycle. A transfer in that same cycle is not captured.
- clear:
  - From any state: counts=0, cap_valid=0 (cap_* fields retain their values), state=IDLE.
  - clear has priority over arm and over capture in the same cycle.
  - A transfer coinciding with clear is acknowledged but neither counted nor captured.
- Outputs are registered, except the ready signals.

Optional Feature:
- Macro: NSDP_ERR_TIMESTAMP_EN.
- Defined:
  - A 32-bit free-running cycle counter resets to 0, increments every clk and wraps at 2^32.
  - cap_time loads the counter value on the capture edge.
  - clear does not reset the counter.
- Undefined:
  - No counter is built; cap_time is constant 0.

Test Plan:
- Reset, then ch0_err_valid=1 code=0x0004 for 1 cycle in IDLE -> ch0_err_ready=1 same cycle; ch0_err_count=1, cap_valid=0, state=0.
- arm pulse, wait 1 cycle; ch1 valid code=0x0010 data=512'hA5..A5 -> cap_valid=1, cap_channel=1, cap_code=0x0010, cap_data matches, irq pulses once, state=2.
- Both valid held for 4 cycles after reset -> grants alternate ch0,ch1,ch0,ch1; counts 2 and 2; only the first (ch0) captured if armed beforehand.
- In HELD, ch0 sends 3 errors -> ch0_err_count +3, cap_* unchanged; then arm -> cap_valid=0, state=1.
- clear and arm in the same cycle as a ch0 transfer while ARMED -> ready=1, count=0, cap_valid=0, state=0.
- With NSDP_ERR_TIMESTAMP_EN, arm at cycle 10, error accepted at cycle 25 -> cap_time=25 relative to reset release. Without the macro -> cap_time=0.

Source files
------------

// File: rtl/nsdp_error_arbiter.sv
// nsdp_error_arbiter
//   Arbitrates the error records of the two NSDP packet checkers into one
//   shared snapshot buffer (code + data + channel). Software arms capture
//   with a one-cycle pulse. The first accepted record after arming is frozen
//   until the next arm or clear. Per-channel saturating error counters run
//   at all times.
//
//   Optional: define NSDP_ERR_TIMESTAMP_EN to build a free-running 32-bit
//   cycle counter. cap_time then latches that counter on capture. Without
//   the macro, cap_time is tied to 0.
//
// Ports
//   clk, resetn                  clock, synchronous active-low reset
//   chN_err_valid/ready          per-channel record handshake (ready is comb)
//   chN_err_code/data            per-channel error record payload
//   arm, clear                   software pulses
//   state                        0=IDLE 1=ARMED 2=HELD
//   cap_valid/channel/code/data  captured snapshot
//   cap_time                     capture timestamp (0 when feature off)
//   chN_err_count                accepted errors since clear (saturating)
//   irq                          one-cycle pulse following a capture
module nsdp_error_arbiter #(
  parameter int DATA_W = 512,
  parameter int CODE_W = 15,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ch0_err_valid,
  output logic              ch0_err_ready,
  input  logic [CODE_W-1:0] ch0_err_code,
  input  logic [DATA_W-1:0] ch0_err_data,
  input  logic              ch1_err_valid,
  output logic              ch1_err_ready,
  input  logic [CODE_W-1:0] ch1_err_code,
  input  logic [DATA_W-1:0] ch1_err_data,
  input  logic              arm,
  input  logic              clear,
  output logic [1:0]        state,
  output logic              cap_valid,
  output logic              cap_channel,
  output logic [CODE_W-1:0] cap_code,
  output logic [DATA_W-1:0] cap_data,
  output logic [31:0]       cap_time,
  output logic [CNT_W-1:0]  ch0_err_count,
  output logic [CNT_W-1:0]  ch1_err_count,
  output logic              irq
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_HELD  = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_last_grant;
  logic              r_cap_valid, r_cap_channel, r_irq;
  logic [CODE_W-1:0] r_cap_code;
  logic [DATA_W-1:0] r_cap_data;
  logic [CNT_W-1:0]  r_cnt0, r_cnt1;
  logic              w_g0, w_g1, w_xfer, w_capture, w_rearm;
  logic [31:0]       w_now;

  // Round-robin on ties: the channel that did not win last gets the grant.
  // Gating with resetn keeps both readys low while reset is asserted.
  assign w_g0   = resetn && ch0_err_valid && (!ch1_err_valid || r_last_grant);
  assign w_g1   = resetn && ch1_err_valid && (!ch0_err_valid || !r_last_grant);
  assign w_xfer = w_g0 || w_g1;

  assign ch0_err_ready = w_g0;
  assign ch1_err_ready = w_g1;

  // clear overrides everything. A transfer in the arm cycle is never
  // captured, because capture happens only out of ARMED.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_rearm     = 1'b0;
    if (clear) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (arm) w_state_nxt = S_ARMED;
        S_ARMED: if (w_xfer) begin
          w_capture   = 1'b1;
          w_state_nxt = S_HELD;
        end
        S_HELD:  if (arm) begin
          w_rearm     = 1'b1;
          w_state_nxt = S_ARMED;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

`ifdef NSDP_ERR_TIMESTAMP_EN
  // Free-running counter; clear leaves it alone.
  logic [31:0] r_cyc;
  always_ff @(posedge clk) begin
    if (!resetn) r_cyc <= '0;
    else         r_cyc <= r_cyc + 32'd1;
  end
  assign w_now = r_cyc;
`else
  assign w_now = '0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_last_grant  <= 1'b1;
      r_cap_valid   <= 1'b0;
      r_cap_channel <= 1'b0;
      r_cap_code    <= '0;
      r_cap_data    <= '0;
      cap_time      <= '0;
      r_cnt0        <= '0;
      r_cnt1        <= '0;
      r_irq         <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_irq   <= w_capture;
      if (w_xfer) r_last_grant <= w_g1;

      if (clear) begin
        r_cnt0 <= '0;
        r_cnt1 <= '0;
      end else begin
        if (w_g0 && r_cnt0 != {CNT_W{1'b1}}) r_cnt0 <= r_cnt0 + CNT_W'(1);
        if (w_g1 && r_cnt1 != {CNT_W{1'b1}}) r_cnt1 <= r_cnt1 + CNT_W'(1);
      end

      if (clear || w_rearm) r_cap_valid <= 1'b0;
      else if (w_capture)   r_cap_valid <= 1'b1;

      if (w_capture) begin
        r_cap_channel <= w_g1;
        r_cap_code    <= w_g1 ? ch1_err_code : ch0_err_code;
        r_cap_data    <= w_g1 ? ch1_err_data : ch0_err_data;
        cap_time      <= w_now;
      end
    end
  end

  assign state         = r_state;
  assign cap_valid     = r_cap_valid;
  assign cap_channel   = r_cap_channel;
  assign cap_code      = r_cap_code;
  assign cap_data      = r_cap_data;
  assign ch0_err_count = r_cnt0;
  assign ch1_err_count = r_cnt1;
  assign irq           = r_irq;

endmodule
